// File: rtl/rpn_stack_exec_if.sv
// rtl/rpn_stack_exec_if.sv - command, stack RAM and status bundle for the RPN stack executor
interface rpn_stack_exec_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    logic              done;
    logic [1:0]        err;
    logic [ADDR_W:0]   sp;
    logic [DATA_W-1:0] top;
    logic              top_valid;

    // front end / RAM / display side
    modport master (
        output cmd_valid, cmd_op, cmd_data, ram_rdata,
        input  cmd_ready, ram_addr, ram_wdata, ram_we,
        input  done, err, sp, top, top_valid
    );

    // executor side
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, ram_rdata,
        output cmd_ready, ram_addr, ram_wdata, ram_we,
        output done, err, sp, top, top_valid
    );
endinterface

// File: rtl/rpn_stack_exec.sv
// rtl/rpn_stack_exec.sv - RPN stack controller and execute unit driving a sync-read stack RAM
module rpn_stack_exec #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    rpn_stack_exec_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PUSH_WR = 3'd1;
    localparam logic [2:0] S_RD_A    = 3'd2;
    localparam logic [2:0] S_RD_B    = 3'd3;
    localparam logic [2:0] S_LATCH_B = 3'd4;
    localparam logic [2:0] S_OP_WR   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DROP = 3'b100;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    localparam logic [ADDR_W:0] SP_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] SP_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] SP_TWO  = (ADDR_W+1)'(2);

    logic [2:0]        state;
    logic [ADDR_W:0]   sp_q;
    logic [DATA_W-1:0] top_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] pdata_q;
    logic [2:0]        op_q;
    logic [1:0]        err_q;

    logic              accept;
    logic [ADDR_W-1:0] sp_lo;
    logic [ADDR_W-1:0] addr_m1;
    logic [ADDR_W-1:0] addr_m2;
    logic [DATA_W-1:0] result;

    assign accept  = (state == S_IDLE) && bus.cmd_valid;
    assign sp_lo   = sp_q[ADDR_W-1:0];
    assign addr_m1 = sp_lo - ADDR_W'(1);
    assign addr_m2 = sp_lo - ADDR_W'(2);

    // B is the deeper operand, so "b a -" subtracts top-of-stack from the one below
    always_comb begin
        result = '0;
        case (op_q)
            OP_ADD:  result = b_q + a_q;
            OP_SUB:  result = b_q - a_q;
            OP_MUL:  result = b_q * a_q;
            default: result = '0;
        endcase
    end

    // RAM port decoded from state so reset drops the write strobe at once
    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_we    = 1'b0;
        case (state)
            S_PUSH_WR: begin
                bus.ram_addr  = sp_lo;
                bus.ram_wdata = pdata_q;
                bus.ram_we    = 1'b1;
            end
            S_RD_A:  bus.ram_addr = addr_m1;
            S_RD_B:  bus.ram_addr = addr_m2;
            S_OP_WR: begin
                bus.ram_addr  = addr_m2;
                bus.ram_wdata = result;
                bus.ram_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            sp_q    <= '0;
            top_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pdata_q <= '0;
            op_q    <= OP_PUSH;
            err_q   <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.cmd_op;
                        pdata_q <= bus.cmd_data;
                        err_q   <= ERR_OK;
                        case (bus.cmd_op)
                            OP_PUSH: begin
                                if (sp_q < SP_FULL) begin
                                    state <= S_PUSH_WR;
                                end else begin
                                    err_q <= ERR_OVER;
                                    state <= S_DONE;
                                end
                            end
                            OP_ADD, OP_SUB, OP_MUL: begin
                                if (sp_q >= SP_TWO) begin
                                    state <= S_RD_A;
                                end else begin
                                    err_q <= ERR_UNDER;
                                    state <= S_DONE;
                                end
                            end
                            OP_DROP: begin
                                // with one entry there is nothing below to fetch
                                if (sp_q >= SP_TWO) begin
                                    state <= S_RD_B;
                                end else if (sp_q == SP_ONE) begin
                                    state <= S_LATCH_B;
                                end else begin
                                    err_q <= ERR_UNDER;
                                    state <= S_DONE;
                                end
                            end
                            default: begin
                                err_q <= ERR_ILL;
                                state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_PUSH_WR: begin
                    sp_q  <= sp_q + SP_ONE;
                    top_q <= pdata_q;
                    state <= S_DONE;
                end
                S_RD_A: state <= S_RD_B;
                S_RD_B: begin
                    a_q   <= bus.ram_rdata;
                    state <= S_LATCH_B;
                end
                S_LATCH_B: begin
                    b_q   <= bus.ram_rdata;
                    state <= (op_q == OP_DROP) ? S_DONE : S_OP_WR;
                end
                S_OP_WR: begin
                    sp_q  <= sp_q - SP_ONE;
                    top_q <= result;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (op_q == OP_DROP && err_q == ERR_OK) begin
                        sp_q  <= sp_q - SP_ONE;
                        top_q <= (sp_q == SP_ONE) ? '0 : b_q;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.err       = err_q;
    assign bus.sp        = sp_q;
    assign bus.top       = top_q;
    assign bus.top_valid = (sp_q != '0);
endmodule

// File: doc/rpn_stack_exec.md
Name: rpn_stack_exec

Overview:
- Stack controller and execute unit for the RPN calculator.
- Owns the stack pointer and the single port of the stack RAM.
- Push writes operands; arithmetic and drop commands read (pop) operands back, compute, and write the result.
- Sits between the key/switch command front end and the synchronous-read stack RAM; drives the top-of-stack value to the HEX display logic.

Parameters:
DATA_W, 8, operand/result width.
ADDR_W, 8, stack RAM address width.
DEPTH, 256, usable stack entries; must be ≤ 2**ADDR_W.

Ports:
CLOCK_50  input  1  system clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command request.
cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid & cmd_ready.
cmd_op  input  3  command code: 000 push, 001 add, 010 sub, 011 mul, 100 drop, others illegal.
cmd_data  input  DATA_W  push operand; sampled at accept.
ram_addr  output  ADDR_W  stack RAM address, shared by read and write.
ram_wdata  output  DATA_W  RAM write data.
ram_we  output  1  RAM write enable.
ram_rdata  input  DATA_W  RAM read data; valid one cycle after ram_addr is presented.
done  output  1  one-cycle pulse at command completion.
err  output  2  completion status, valid with done: 00 ok, 01 underflow, 10 overflow, 11 illegal.
sp  output  ADDR_W+1  entry count; next free slot.
top  output  DATA_W  value of mem[sp-1]; 0 when empty.
top_valid  output  1  sp != 0.

Behaviour:
- Reset (asynchronous): state=IDLE, sp=0, top=0, top_valid=0, done=0, err=00, ram_we=0, ram_addr=0, ram_wdata=0. RAM contents are not cleared. Reset mid-command abandons the command with no write and no done.
- ram_we is decoded from state, so reset deasserts it immediately.
- FSM states: IDLE, PUSH_WR, RD_A, RD_B, LATCH_B, OP_WR, DONE.
- Accept at cycle T leaves IDLE.
- Push, sp < DEPTH:
  - T+1 PUSH_WR: ram_addr=sp, ram_wdata=cmd_data, ram_we=1; sp <= sp+1, top <= cmd_data.
  - T+2 DONE: done=1, err=00.
- Push, sp == DEPTH: go straight to DONE at T+1 with err=10; no write; sp unchanged.
- add/sub/mul, sp ≥ 2:
  - RD_A (T+1): ram_addr=sp-1.
  - RD_B (T+2): ram_addr=sp-2; A <= ram_rdata.
  - LATCH_B (T+3): B <= ram_rdata.
  - OP_WR (T+4): ram_addr=sp-2, ram_we=1, ram_wdata=R; sp <= sp-1, top <= R.
  - DONE (T+5): done=1.
- Result R: add B+A; sub B-A (RPN order: "5 3 -" = 2); mul low DATA_W bits of B*A. All arithmetic is modulo 2**DATA_W, with no carry or overflow flag.
- Drop, sp ≥ 1: RD_B with ram_addr=sp-2 (skipped when sp==1), then LATCH_B, then DONE. At DONE: sp <= sp-1, top <= B (or 0 if the new sp is 0).
- Underflow: op with sp < 2, or drop with sp == 0 → DONE at T+1, err=01, no RAM write, sp/top unchanged.
- Illegal cmd_op → DONE at T+1, err=11, no state change.
- DONE always returns to IDLE the next cycle. cmd_valid is ignored while cmd_ready=0; there is no queuing.
- top_valid equals (sp != 0) at all times.

Test Plan:
- Push 5, push 3, sub → done with err=00, top=2, sp=1, mem[0]=2; OP_WR occurs exactly 4 cycles after accept.
- Push 200, push 100, add → top=44 (wrap). Push 16, push 16, mul → top=0. Push 7, push 6, mul → top=42.
- Reset, push 9, add → err=01, sp=1, top=9, ram_we never asserted. Reset, drop → err=01, sp=0.
- DEPTH=4: push 1,2,3,4 then push 5 → err=10, sp=4, top=4, no write to any address.
- Push 1, push 2, drop → top=1, sp=1; drop → top=0, top_valid=0, sp=0.
- Assert RESET during RD_B of an add → immediate IDLE, sp=0, ram_we=0, no done; next push 8 → mem[0]=8, top=8.
